// File: rtl/test_mux_scan_seq_if.sv
// Bus between the test-mux scan sequencer and its surroundings: config/handshake
// from the IO register block and scope, channel select/write enables to the mux bank.
interface test_mux_scan_seq_if #(
  parameter int CMuxCnt  = 2,
  parameter int CSettleW = 8
) ();
  logic                  AStart;
  logic                  AStop;
  logic                  ALoop;
  logic [5:0]            AStepCnt;
  logic [6*CMuxCnt-1:0]  ABaseIdx;
  logic [CSettleW-1:0]   ASettle;
  logic                  ACapAck;
  logic [5:0]            ASelIdx;
  logic [CMuxCnt-1:0]    ASelWrEn;
  logic                  ACapReq;
  logic                  ABusy;
  logic [5:0]            AStepIdx;
  logic                  ADone;

  // master: the sequencer itself
  modport master (
    input  AStart, AStop, ALoop, AStepCnt, ABaseIdx, ASettle, ACapAck,
    output ASelIdx, ASelWrEn, ACapReq, ABusy, AStepIdx, ADone
  );

  // slave: register block, scope and mux bank side
  modport slave (
    output AStart, AStop, ALoop, AStepCnt, ABaseIdx, ASettle, ACapAck,
    input  ASelIdx, ASelWrEn, ACapReq, ABusy, AStepIdx, ADone
  );
endinterface

// File: rtl/test_mux_scan_seq.sv
// Steps a bank of test-signal muxes through a channel range: load every mux,
// wait the settle time, handshake one scope capture, then advance the step.
module test_mux_scan_seq #(
  parameter int CMuxCnt  = 2,
  parameter int CSettleW = 8
) (
  input  logic                 AClkH,
  input  logic                 AResetHN,
  input  logic                 AClkHEn,
  test_mux_scan_seq_if.master  bus
);
  localparam int MuxW = (CMuxCnt > 1) ? $clog2(CMuxCnt) : 1;
  localparam logic [MuxW-1:0] MuxLast = MuxW'(CMuxCnt - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SETTLE,
    ST_CAPT,
    ST_NEXT
  } state_t;

  state_t                state_q, state_d;
  logic [5:0]            step_q, step_d;
  logic [MuxW-1:0]       mux_q, mux_d;
  logic [CSettleW-1:0]   settle_q, settle_d;
  logic [5:0]            sel_idx_q, sel_idx_d;
  logic [CMuxCnt-1:0]    sel_wr_en_q, sel_wr_en_d;
  logic                  cap_req_q, cap_req_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  last_step;
  logic [5:0]            base_idx [CMuxCnt];

  generate
    for (genvar gi = 0; gi < CMuxCnt; gi++) begin : g_base
      assign base_idx[gi] = bus.ABaseIdx[6*gi +: 6];
    end
  endgenerate

  // A step count of 0 wraps to 63 here, which gives the 64-step case for free
  assign last_step = (step_q == 6'(bus.AStepCnt - 6'd1));

  always_comb begin
    state_d  = state_q;
    step_d   = step_q;
    mux_d    = mux_q;
    settle_d = settle_q;
    done_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.AStart && !bus.AStop) begin
          state_d = ST_LOAD;
          step_d  = 6'd0;
          mux_d   = '0;
        end
      end
      ST_LOAD: begin
        if (mux_q == MuxLast) begin
          mux_d = '0;
          if (bus.ASettle == '0) begin
            state_d = ST_CAPT;
          end else begin
            state_d  = ST_SETTLE;
            settle_d = bus.ASettle;
          end
        end else begin
          mux_d = mux_q + 1'b1;
        end
      end
      ST_SETTLE: begin
        settle_d = settle_q - 1'b1;
        if (settle_q <= CSettleW'(1)) begin
          state_d = ST_CAPT;
        end
      end
      ST_CAPT: begin
        if (bus.ACapAck) begin
          state_d = ST_NEXT;
        end
      end
      ST_NEXT: begin
        if (!last_step) begin
          step_d  = step_q + 6'd1;
          state_d = ST_LOAD;
        end else if (bus.ALoop) begin
          step_d  = 6'd0;
          state_d = ST_LOAD;
        end else begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Abort wins over everything; the muxes simply keep their last selection
    if (state_q != ST_IDLE && bus.AStop) begin
      state_d  = ST_IDLE;
      step_d   = 6'd0;
      mux_d    = '0;
      settle_d = '0;
      done_d   = 1'b0;
    end

    // Outputs are registered from the next state so nothing is combinational from inputs
    sel_wr_en_d = '0;
    sel_idx_d   = 6'd0;
    if (state_d == ST_LOAD) begin
      sel_wr_en_d[mux_d] = 1'b1;
      sel_idx_d          = base_idx[mux_d] + step_d;
    end
    cap_req_d = (state_d == ST_CAPT);
    busy_d    = (state_d != ST_IDLE);
  end

  always_ff @(posedge AClkH) begin
    if (!AResetHN) begin
      state_q     <= ST_IDLE;
      step_q      <= 6'd0;
      mux_q       <= '0;
      settle_q    <= '0;
      sel_idx_q   <= 6'd0;
      sel_wr_en_q <= '0;
      cap_req_q   <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else if (AClkHEn) begin
      state_q     <= state_d;
      step_q      <= step_d;
      mux_q       <= mux_d;
      settle_q    <= settle_d;
      sel_idx_q   <= sel_idx_d;
      sel_wr_en_q <= sel_wr_en_d;
      cap_req_q   <= cap_req_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign bus.ASelIdx  = sel_idx_q;
  assign bus.ASelWrEn = sel_wr_en_q;
  assign bus.ACapReq  = cap_req_q;
  assign bus.ABusy    = busy_q;
  assign bus.AStepIdx = step_q;
  assign bus.ADone    = done_q;
endmodule

// File: doc/test_mux_scan_seq.md
Name: test_mux_scan_seq

Overview:
- Sequencer that drives the select-write inputs of a bank of 8-bit test-signal multiplexers.
- It steps each mux through a range of its 64 input channels.
- At each step it waits a settle time, then handshakes with the scope capture logic before advancing.
- It sits between the IO register block (start/stop/config) and the test mux bank, replacing manual per-step host writes.

Parameters:
- CMuxCnt, 2, number of muxes sequenced (1..16).
- CSettleW, 8, width of the settle counter and ASettle port.

Ports:
- AClkH  in  1  clock.
- AResetHN  in  1  synchronous active-low reset.
- AClkHEn  in  1  clock enable; state advances only when 1.
- AStart  in  1  start request, level sampled in IDLE.
- AStop  in  1  abort request.
- ALoop  in  1  1 = wrap to step 0 after last step and continue.
- AStepCnt  in  6  number of steps; 0 means 64.
- ABaseIdx  in  6*CMuxCnt  per-mux base channel; mux m uses bits [6m+5:6m].
- ASettle  in  CSettleW  settle cycles after load.
- ACapAck  in  1  capture-done acknowledge from scope.
- ASelIdx  out  6  channel index to mux bank (shared bus).
- ASelWrEn  out  CMuxCnt  one-hot write enable, bit m loads mux m.
- ACapReq  out  1  capture request.
- ABusy  out  1  high in any state except IDLE.
- AStepIdx  out  6  current step number.
- ADone  out  1  one-cycle pulse on normal completion.

Behaviour:
- Reset (AResetHN=0 at a rising AClkH edge): state IDLE, step=0, mux counter=0, settle counter=0, all outputs 0.
- Reset overrides AClkHEn.
- When AClkHEn=0: all registers hold and outputs hold their values. ADone remains high if it was high.
- All transitions below are taken only on enabled edges. "Cycle" means an enabled cycle.
- Outputs are decoded from registered state (Moore). No input-to-output combinational path.
- IDLE:
  - AStart=1 and AStop=0 -> LOAD, step=0, m=0.
  - AStart while not IDLE is ignored.
- LOAD:
  - Lasts exactly CMuxCnt cycles, m=0..CMuxCnt-1.
  - ASelWrEn = one-hot(m).
  - ASelIdx = (ABaseIdx[m] + step) mod 64, 6-bit wrap with no carry out.
  - After m=CMuxCnt-1: if ASettle=0 -> CAPT, else SETTLE with counter=ASettle.
- SETTLE:
  - Counter decrements each cycle.
  - Leaving at count 1 -> CAPT. Exactly ASettle cycles are spent in SETTLE.
- CAPT:
  - ACapReq=1, held until ACapAck=1 is sampled; then -> NEXT.
  - ACapReq deasserts in NEXT.
  - ACapAck outside CAPT is ignored.
- NEXT (1 cycle):
  - If step = last (AStepCnt-1, or 63 when AStepCnt=0):
    - ALoop=1 -> step=0, LOAD.
    - ALoop=0 -> IDLE with ADone=1 for that one cycle.
  - Otherwise step+1, LOAD.
- ASelWrEn is 0 in all states except LOAD. ASelIdx is 0 outside LOAD.
- AStop=1 in any non-IDLE state -> IDLE next cycle:
  - ACapReq, ASelWrEn and ABusy clear.
  - No ADone pulse; step resets to 0.
  - Muxes keep their last-written selections.
- AStop and AStart both high in IDLE: stay IDLE.
- Config inputs (ABaseIdx, AStepCnt, ASettle, ALoop) are sampled live. Changing them mid-run takes effect at the next point of use. Software changes them only while ABusy=0.
- AStepIdx = current step register.
- ABusy=1 from the cycle after start acceptance until return to IDLE.

Test Plan:
1. CMuxCnt=2, ABaseIdx={6'd10,6'd3}, AStepCnt=3, ASettle=2, ALoop=0, ACapAck one cycle after each ACapReq, AStart pulse.
   - Required write pairs: (m0=3,m1=10), (4,11), (5,12).
   - Per step: 2 settle cycles, then ACapReq.
   - After 3rd ack: ADone single pulse, ABusy falls, 3 ACapReq total.
2. Wrap: ABaseIdx[0]=62, AStepCnt=4 -> mux0 indices 62,63,0,1. AStepCnt=0 -> 64 steps, AStepIdx reaches 63, then ADone.
3. ASettle=0 -> ACapReq asserts the cycle immediately after the last LOAD write. ACapAck held low 20 cycles -> ACapReq stays high 20+ cycles, no step advance.
4. ALoop=1, AStepCnt=2 -> step sequence 0,1,0,1,...; no ADone. AStop during CAPT -> IDLE next cycle, ACapReq=0, ABusy=0, no ADone.
5. AClkHEn toggled 1-in-3 during run 1 -> identical output sequence in enabled cycles, all outputs frozen on disabled cycles.
6. Synchronous reset asserted mid-SETTLE -> at next edge all outputs 0, state IDLE. AStart while busy -> ignored, no sequence restart.
